ifu_fetch: RTL and testbench

Instruction fetch stage directly upstream of the decode unit. It owns the PC, issues word fetches to instruction memory over a valid/ready request channel, and buffers returned instructions with their PCs in a small FIFO. It presents one instruction per cycle to decode under a valid/ready handshake. On a redirect from the branch/jump resolution logic it flushes the buffer and discards in-flight responses.

---
 rtl/ifu_fetch_pkg.sv | 14 +
 rtl/ifu_fifo.sv | 54 +++++
 rtl/ifu_fetch.sv | 69 ++++++
 tb/tb_ifu_fetch.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared widths, reset PC and the buffered fetch-entry type
package ifu_fetch_pkg;
  localparam int XLEN = 64;
  localparam int INSTR_SIZE = 32;
  localparam int FIFO_DEPTH = 2;
  localparam logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000;
  typedef struct packed {
    logic [INSTR_SIZE-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: small synchronous FIFO of fetch entries with registered head and flush
module ifu_fifo import ifu_fetch_pkg::*; #(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  fetch_entry_t din,
  input  logic pop,
  input  logic flush,
  output fetch_entry_t head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic full,
  output logic empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH-1) ? '0 : p + AW'(1);
  endfunction
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rd_ptr];
  // storage and pointers; flush empties the buffer regardless of push/pop
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  // credit accounting upstream must never overfill or underflow the buffer
  always_ff @(posedge clk)
    if (!rst && !flush) begin
      assert (!(push && full));
      assert (!(pop && empty));
    end
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: PC ownership, credit-limited imem requests, redirect flush and drop of stale responses
module ifu_fetch import ifu_fetch_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic imem_req_valid,
  input  logic imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic imem_resp_valid,
  input  logic [INSTR_SIZE-1:0] imem_resp_data,
  output logic instr_valid,
  input  logic instr_ready,
  output logic [INSTR_SIZE-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  logic [XLEN-1:0] pc_q, resp_pc_q;
  logic [CW-1:0] outstanding, drop_cnt, count;
  logic [CW:0] credit;
  logic pop, accept, push, full, empty;
  fetch_entry_t head;
  assign pop = instr_valid && instr_ready;
  assign credit = {1'b0, outstanding} + {1'b0, count} - (CW+1)'(pop);
  assign imem_req_valid = !rst && !redirect_valid && drop_cnt == '0 && credit < (CW+1)'(FIFO_DEPTH);
  assign imem_req_addr = pc_q;
  assign accept = imem_req_valid && imem_req_ready;
  assign push = imem_resp_valid && !redirect_valid && drop_cnt == '0;
  assign instr_valid = !empty;
  assign instr = head.instr;
  assign instr_pc = head.pc;
  ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din('{instr: imem_resp_data, pc: resp_pc_q}),
    .pop(pop),
    .flush(redirect_valid),
    .head(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  // PC, in-flight count and drop counter; a redirect restarts both PCs and drops whatever is still in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_q <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_resp_valid);
      if (redirect_valid) begin
        pc_q <= align_pc(redirect_pc);
        resp_pc_q <= align_pc(redirect_pc);
        drop_cnt <= outstanding - CW'(imem_resp_valid);
      end else begin
        if (accept) pc_q <= pc_q + XLEN'(4);
        if (imem_resp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        if (push) resp_pc_q <= resp_pc_q + XLEN'(4);
      end
    end
  // responses only ever answer an accepted request, and credits keep pushes off a full buffer
  always_ff @(posedge clk)
    if (!rst) begin
      assert (!(imem_resp_valid && outstanding == '0));
      assert (!(push && full));
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed table-driven and sequence checks of the fetch stage
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic redirect_valid, imem_req_valid, imem_req_ready, imem_resp_valid;
  logic instr_valid, instr_ready;
  logic [XLEN-1:0] redirect_pc, imem_req_addr, instr_pc;
  logic [INSTR_SIZE-1:0] imem_resp_data, instr;
  int tests = 0, failed = 0, lat = 1, cyc;
  localparam logic [XLEN-1:0] B = RESET_PC;
  typedef struct { logic [XLEN-1:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  typedef struct { bit ir; bit qr; bit rv; logic [7:0] a; bit iv; logic [7:0] p; } vec_t;
  vec_t v[18];

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc)
  );

  function automatic logic [INSTR_SIZE-1:0] mdata(input logic [XLEN-1:0] a);
    return a[31:0] ^ 32'h1357_9bdf;
  endfunction

  // in-order memory: a request accepted in cycle k answers in cycle k+lat
  always @(posedge clk or posedge rst)
    if (rst) begin
      mq.delete();
      imem_resp_valid <= 1'b0;
      imem_resp_data <= '0;
      cyc <= 0;
    end else begin
      cyc <= cyc + 1;
      if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, cyc + lat});
      if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
        imem_resp_valid <= 1'b1;
        imem_resp_data <= mdata(mq[0].addr);
        void'(mq.pop_front());
      end else imem_resp_valid <= 1'b0;
    end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b1;
    imem_req_ready = 1'b1;
    lat = l;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr_pc", instr_pc, 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    v[0]  = '{1, 1, 1, 8'h00, 0, 8'h00};
    v[1]  = '{1, 1, 1, 8'h04, 0, 8'h00};
    v[2]  = '{1, 1, 1, 8'h08, 1, 8'h00};
    v[3]  = '{1, 1, 1, 8'h0c, 1, 8'h04};
    v[4]  = '{1, 1, 1, 8'h10, 1, 8'h08};
    v[5]  = '{0, 1, 0, 8'h00, 1, 8'h0c};
    v[6]  = '{0, 1, 0, 8'h00, 1, 8'h0c};
    v[7]  = '{0, 1, 0, 8'h00, 1, 8'h0c};
    v[8]  = '{0, 1, 0, 8'h00, 1, 8'h0c};
    v[9]  = '{0, 1, 0, 8'h00, 1, 8'h0c};
    v[10] = '{1, 1, 1, 8'h14, 1, 8'h0c};
    v[11] = '{1, 1, 1, 8'h18, 1, 8'h10};
    v[12] = '{1, 0, 1, 8'h1c, 1, 8'h14};
    v[13] = '{1, 0, 1, 8'h1c, 1, 8'h18};
    v[14] = '{1, 0, 1, 8'h1c, 0, 8'h00};
    v[15] = '{1, 1, 1, 8'h1c, 0, 8'h00};
    v[16] = '{1, 1, 1, 8'h20, 0, 8'h00};
    v[17] = '{1, 1, 1, 8'h24, 1, 8'h1c};
    // streaming, decode stall and memory stall with 1-cycle memory
    do_reset(1);
    for (int i = 0; i < 18; i++) begin
      if (i > 0) @(negedge clk);
      instr_ready = v[i].ir;
      imem_req_ready = v[i].qr;
      #1;
      chk($sformatf("vec%0d_req_valid", i), 64'(imem_req_valid), 64'(v[i].rv));
      if (v[i].rv) chk($sformatf("vec%0d_req_addr", i), imem_req_addr, B + 64'(v[i].a));
      chk($sformatf("vec%0d_instr_valid", i), 64'(instr_valid), 64'(v[i].iv));
      if (v[i].iv) begin
        chk($sformatf("vec%0d_instr_pc", i), instr_pc, B + 64'(v[i].p));
        chk($sformatf("vec%0d_instr", i), 64'(instr), 64'(mdata(B + 64'(v[i].p))));
      end
    end
    // redirect with two responses in flight, 3-cycle memory
    @(negedge clk);
    do_reset(3);
    #1 chk("t4_c0_addr", imem_req_addr, B);
    @(negedge clk);
    #1 chk("t4_c1_addr", imem_req_addr, B + 64'h4);
    @(negedge clk);
    redirect_pc = B + 64'h1002;
    redirect_valid = 1'b1;
    #1 chk("t4_R_req_valid", 64'(imem_req_valid), 64'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int c = 3; c <= 4; c++) begin
      #1;
      chk($sformatf("t4_c%0d_req_valid", c), 64'(imem_req_valid), 64'd0);
      chk($sformatf("t4_c%0d_instr_valid", c), 64'(instr_valid), 64'd0);
      @(negedge clk);
    end
    #1 chk("t4_c5_req_valid", 64'(imem_req_valid), 64'd1);
    chk("t4_c5_addr", imem_req_addr, B + 64'h1000);
    n = 0;
    while (!instr_valid && n < 10) begin
      @(negedge clk);
      #1 n++;
    end
    chk("t4_first_valid", 64'(instr_valid), 64'd1);
    chk("t4_latency", 64'(n), 64'd4);
    chk("t4_first_pc", instr_pc, B + 64'h1000);
    chk("t4_first_instr", 64'(instr), 64'(mdata(B + 64'h1000)));
    // redirect coinciding with a response and a pop
    @(negedge clk);
    do_reset(1);
    @(negedge clk);
    @(negedge clk);
    redirect_pc = B + 64'h2000;
    redirect_valid = 1'b1;
    #1 chk("t5_R_instr_valid", 64'(instr_valid), 64'd1);
    chk("t5_R_resp_valid", 64'(imem_resp_valid), 64'd1);
    chk("t5_R_req_valid", 64'(imem_req_valid), 64'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1 chk("t5_R1_instr_valid", 64'(instr_valid), 64'd0);
    chk("t5_R1_req_valid", 64'(imem_req_valid), 64'd1);
    chk("t5_R1_addr", imem_req_addr, B + 64'h2000);
    @(negedge clk);
    #1 chk("t5_R2_instr_valid", 64'(instr_valid), 64'd0);
    @(negedge clk);
    #1 chk("t5_R3_instr_valid", 64'(instr_valid), 64'd1);
    chk("t5_R3_pc", instr_pc, B + 64'h2000);
    // reset mid-stream with the buffer full
    @(negedge clk);
    do_reset(1);
    instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("t6_full_instr_valid", 64'(instr_valid), 64'd1);
    chk("t6_full_req_valid", 64'(imem_req_valid), 64'd0);
    chk("t6_full_pc", instr_pc, B);
    #1 rst = 1'b1;
    #1 chk("t6_rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("t6_rst_req_valid", 64'(imem_req_valid), 64'd0);
    do_reset(1);
    #1 chk("t6_restart_req_valid", 64'(imem_req_valid), 64'd1);
    chk("t6_restart_addr", imem_req_addr, B);
    chk("t6_restart_instr_valid", 64'(instr_valid), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
